shift_seq_ctrl: RTL and testbench
=================================

// Module: shift_seq_ctrl
// PURPOSE
//   Multi-cycle sequencer for the 32-bit shift datapath: accepts one operand, shift amount and op via valid/ready,
//   applies one power-of-two stage per clock (16,8,4,2,1) through a single shared stage unit, returns result
//   via valid/ready. Sits between ALU issue logic and result writeback; one operation in flight at a time.
// PARAMETERS
//   WIDTH      32   operand/result width; must be a power of two, >= 2
//   AMT_W      5    shift-amount width; equals log2(WIDTH); stage count = AMT_W
//   ZERO_SKIP  1    1: amt==0 bypasses SHIFT state (DONE next edge); 0: always walks all AMT_W stages
// PORTS
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous, active-high reset
//   in_valid   in   1       request present
//   in_ready   out  1       block can accept request (IDLE only)
//   in_data    in   WIDTH   operand
//   in_amt     in   AMT_W   shift amount, 0..WIDTH-1
//   in_op      in   2       00 SHL, 01 SHR logical, 10 SAR arithmetic, 11 ROL rotate-left
//   out_valid  out  1       result valid (DONE state)
//   out_ready  in   1       consumer takes result
//   out_data   out  WIDTH   shifted result; held stable while out_valid && !out_ready
//   busy       out  1       state != IDLE
// BEHAVIOUR
//   Reset (async assert, sync-safe release): state=IDLE, data_r=0, amt_r=0, op_r=00, stage_cnt=AMT_W-1;
//     outputs: in_ready=0 while rst high, 1 after release; out_valid=0; out_data=0; busy=0.
//   States: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: in_ready=1. Accept on in_valid&&in_ready at edge: latch data/amt/op, stage_cnt=AMT_W-1 (bit 4 = 16).
//     amt==0 && ZERO_SKIP=1 -> DONE (out_valid 1 cycle after accept edge); else -> SHIFT.
//   SHIFT: each edge, if amt_r[stage_cnt] then data_r <= stage(data_r, 2**stage_cnt, op_r) else unchanged;
//     stage_cnt decrements; edge with stage_cnt==0 -> DONE. Fixed latency: out_valid high AMT_W (5) cycles
//     after accept edge, independent of amount value (except ZERO_SKIP case).
//   DONE: out_valid=1, out_data=data_r. On out_valid&&out_ready edge -> IDLE; in_ready returns next cycle
//     (no same-cycle accept; max throughput one op per AMT_W+2 cycles).
//   in_valid/in_data ignored outside IDLE; out_ready ignored outside DONE.
//   Stage rules (shift by s): SHL fill low s bits with 0; SHR fill high s bits with 0;
//     SAR fill high s bits with data_r[WIDTH-1] (sign preserved across stages, so equals original sign);
//     ROL out = {d[WIDTH-1-s:0], d[WIDTH-1:WIDTH-s]}. No carry/overflow output.
//   Reset mid-operation: any state returns to IDLE immediately; partial result discarded, out_valid drops
//     asynchronously with rst.
//   in_amt >= WIDTH impossible by width; no saturation logic.
// STRUCTURE
//   Shared include shift_defs.vh: op codes (OP_SHL/OP_SHR/OP_SAR/OP_ROL), state encodings
//     (ST_IDLE/ST_SHIFT/ST_DONE, 2-bit binary), default WIDTH/AMT_W.
//   One sub-module: shift_stage (combinational) - in d, stage index, op -> out; mux of the five
//     power-of-two shift variants per op. Controller holds FSM, stage counter, data/amt/op registers only.
// TESTING
//   SHL: data=0x0000_0001 amt=31 -> out_valid at cycle 5 after accept, out_data=0x8000_0000.
//   SAR: data=0x8000_00F0 amt=4 -> 0xF800_000F; SHR same input -> 0x0800_000F.
//   ROL: data=0x1234_5678 amt=8 -> 0x3456_7812; amt=0 with ZERO_SKIP=1 -> 0x1234_5678 at cycle 1.
//   Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid/out_data stable, in_ready=0,
//     new in_valid ignored; release -> IDLE, in_ready=1 next cycle.
//   Reset mid-SHIFT: assert rst at stage 2 -> out_valid=0, busy=0 immediately; next request 0xFFFF_FFFF
//     SHL 16 -> 0xFFFF_0000 (no residue).
//   Random: 10k ops all 4 ops/amts vs reference model, random in_valid/out_ready gaps; check latency
//     and no dropped/duplicated results.

Source files
------------

// File: rtl/shift_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl_pkg : op codes, FSM states and sizing helpers for the shifter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package shift_seq_ctrl_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_AMT_W = 5;

  typedef enum logic [1:0] {
    OP_SHL = 2'b00,
    OP_SHR = 2'b01,
    OP_SAR = 2'b10,
    OP_ROL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Stage counter needs to index AMT_W stages; keep at least one bit.
  function automatic int cnt_width(input int amt_w);
    return (amt_w > 1) ? $clog2(amt_w) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl_if : request/result handshake bundle of the shift sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface shift_seq_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport master (
    output in_valid, in_data, in_amt, in_op, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_op, out_ready,
    output in_ready, out_valid, out_data, busy
  );

endinterface

`default_nettype wire

// File: rtl/shift_seq_ctrl_stage.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl_stage : one power-of-two shift step (2**idx) for the given op
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module shift_seq_ctrl_stage
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5,
  parameter int CNT_W = 3
) (
  input  logic [WIDTH-1:0] d,
  input  logic [CNT_W-1:0] idx,
  input  op_e              op,
  output logic [WIDTH-1:0] q
);

  logic [AMT_W-1:0][WIDTH-1:0] variant;

  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    localparam int S = 1 << k;
    logic [WIDTH-1:0] rol;
    assign rol = {d[WIDTH-1-S:0], d[WIDTH-1:WIDTH-S]};
    assign variant[k] = (op == OP_SHL) ? (d << S) :
                        (op == OP_SHR) ? (d >> S) :
                        (op == OP_SAR) ? WIDTH'($signed(d) >>> S) :
                                         rol;
  end

  always_comb begin
    q = d;
    for (int k = 0; k < AMT_W; k++) begin
      if (idx == CNT_W'(k)) q = variant[k];
    end
  end

endmodule

`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl : multi-cycle shift sequencer, one 2**k stage per clock (MSB first)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int AMT_W     = DEF_AMT_W,
  parameter int ZERO_SKIP = 1
) (
  input  logic            clk,
  input  logic            rst,
  shift_seq_ctrl_if.slave io
);

  localparam int             CNT_W   = cnt_width(AMT_W);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(AMT_W - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [AMT_W-1:0] amt_q,   amt_d;
  op_e              op_q,    op_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] stage_out;

  shift_seq_ctrl_stage #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W),
    .CNT_W (CNT_W)
  ) u_stage (
    .d   (data_q),
    .idx (cnt_q),
    .op  (op_q),
    .q   (stage_out)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    amt_d   = amt_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        // in_ready is IDLE-and-not-in-reset; reset already overrides the flops.
        if (io.in_valid) begin
          data_d  = io.in_data;
          amt_d   = io.in_amt;
          op_d    = op_e'(io.in_op);
          cnt_d   = CNT_TOP;
          state_d = ((ZERO_SKIP != 0) && (io.in_amt == '0)) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (amt_q[cnt_q]) data_d = stage_out;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          cnt_d   = CNT_TOP;
        end else begin
          cnt_d   = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (io.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      amt_q   <= '0;
      op_q    <= OP_SHL;
      cnt_q   <= CNT_TOP;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign io.in_ready  = (state_q == ST_IDLE) && !rst;
  assign io.out_valid = (state_q == ST_DONE);
  assign io.out_data  = data_q;
  assign io.busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_seq_ctrl : directed vector table plus handshake/reset corner sequences
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_shift_seq_ctrl;

  localparam int WIDTH = 32;
  localparam int AMT_W = 5;

  logic clk;
  logic rst;

  shift_seq_ctrl_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) io ();

  shift_seq_ctrl #(
    .WIDTH     (WIDTH),
    .AMT_W     (AMT_W),
    .ZERO_SKIP (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] d;
    logic [4:0]  a;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [16];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Whole-amount reference, independent of the stage decomposition.
  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d, input logic [4:0] a);
    case (op)
      2'd0:    return d << a;
      2'd1:    return d >> a;
      2'd2:    return 32'($signed(d) >>> a);
      default: return (a == 5'd0) ? d : ((d << a) | (d >> (32 - int'(a))));
    endcase
  endfunction

  task automatic send(input logic [1:0] op, input logic [31:0] d, input logic [4:0] a, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    io.in_valid = 1'b1;
    io.in_op    = op;
    io.in_data  = d;
    io.in_amt   = a;
    t = 0;
    while (!io.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!io.in_ready) check("in_ready_timeout", 32'(io.in_ready), 32'd1);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid is seen.
  task automatic wait_done(output int extra);
    extra = 0;
    while (!io.out_valid && extra < 20) begin
      @(posedge clk);
      #1;
      extra++;
    end
    if (!io.out_valid) check("out_valid_timeout", 32'(io.out_valid), 32'd1);
  endtask

  task automatic pop(input int hold);
    repeat (hold) @(negedge clk);
    @(negedge clk);
    io.out_ready = 1'b1;
    @(posedge clk);
    #1;
    io.out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] d, input logic [4:0] a,
                        input int gap, input int hold, input string name);
    int          extra;
    logic [31:0] res;
    send(op, d, a, gap);
    wait_done(extra);
    res = io.out_data;
    check({name, "_data"}, res, ref_shift(op, d, a));
    check({name, "_latency"}, 32'(extra), (a == 5'd0) ? 32'd0 : 32'(AMT_W));
    pop(hold);
  endtask

  initial begin
    int          extra;
    logic [31:0] held;

    vecs[0]  = '{2'd0, 32'h0000_0001, 5'd31, 32'h8000_0000};
    vecs[1]  = '{2'd2, 32'h8000_00F0, 5'd4,  32'hF800_000F};
    vecs[2]  = '{2'd1, 32'h8000_00F0, 5'd4,  32'h0800_000F};
    vecs[3]  = '{2'd3, 32'h1234_5678, 5'd8,  32'h3456_7812};
    vecs[4]  = '{2'd3, 32'h1234_5678, 5'd0,  32'h1234_5678};
    vecs[5]  = '{2'd0, 32'hFFFF_FFFF, 5'd16, 32'hFFFF_0000};
    vecs[6]  = '{2'd1, 32'h8000_0000, 5'd31, 32'h0000_0001};
    vecs[7]  = '{2'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
    vecs[8]  = '{2'd2, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
    vecs[9]  = '{2'd3, 32'h8000_0001, 5'd1,  32'h0000_0003};
    vecs[10] = '{2'd3, 32'h1234_5678, 5'd31, 32'h091A_2B3C};
    vecs[11] = '{2'd0, 32'hA5A5_A5A5, 5'd5,  32'hB4B4_B4A0};
    vecs[12] = '{2'd1, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    vecs[13] = '{2'd2, 32'h8765_4321, 5'd12, 32'hFFF8_7654};
    vecs[14] = '{2'd0, 32'h0000_00FF, 5'd24, 32'hFF00_0000};
    vecs[15] = '{2'd1, 32'h1234_5678, 5'd21, 32'h0000_0091};

    rst          = 1'b1;
    io.in_valid  = 1'b0;
    io.in_data   = '0;
    io.in_amt    = '0;
    io.in_op     = '0;
    io.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(io.in_ready),  32'd0);
    check("rst_out_valid", 32'(io.out_valid), 32'd0);
    check("rst_out_data",  io.out_data,       32'd0);
    check("rst_busy",      32'(io.busy),      32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(io.in_ready), 32'd1);

    // Directed table: result and fixed latency per vector.
    for (int i = 0; i < 16; i++) begin
      int          lat;
      logic [31:0] res;
      send(vecs[i].op, vecs[i].d, vecs[i].a, 0);
      wait_done(lat);
      res = io.out_data;
      check($sformatf("vec%0d_data", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), (vecs[i].a == 5'd0) ? 32'd0 : 32'd5);
      pop(0);
    end

    // Backpressure: result held while out_ready is low, new requests ignored.
    send(2'd3, 32'h1234_5678, 5'd8, 0);
    wait_done(extra);
    held = io.out_data;
    check("bp_first_data", held, 32'h3456_7812);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      io.in_valid = 1'b1;
      io.in_data  = 32'hCAFE_0000 + 32'(c);
      io.in_amt   = 5'd3;
      io.in_op    = 2'd0;
      check("bp_out_valid", 32'(io.out_valid), 32'd1);
      check("bp_out_data",  io.out_data,       held);
      check("bp_in_ready",  32'(io.in_ready),  32'd0);
    end
    @(negedge clk);
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    @(posedge clk);
    #1;
    io.out_ready = 1'b0;
    check("bp_release_in_ready",  32'(io.in_ready),  32'd1);
    check("bp_release_out_valid", 32'(io.out_valid), 32'd0);
    repeat (2) @(negedge clk);
    check("bp_no_ghost_op", 32'(io.busy), 32'd0);

    // Reset in the middle of SHIFT.
    send(2'd0, 32'h0F0F_0F0F, 5'd7, 0);
    repeat (2) @(negedge clk);
    check("mid_busy_before", 32'(io.busy), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_busy",      32'(io.busy),      32'd0);
    check("mid_rst_out_valid", 32'(io.out_valid), 32'd0);
    check("mid_rst_in_ready",  32'(io.in_ready),  32'd0);
    check("mid_rst_out_data",  io.out_data,       32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rel_in_ready", 32'(io.in_ready), 32'd1);
    run_op(2'd0, 32'hFFFF_FFFF, 5'd16, 0, 0, "after_rst");

    // Reset while DONE drops out_valid without waiting for a clock edge.
    send(2'd1, 32'hFFFF_0000, 5'd8, 0);
    wait_done(extra);
    check("done_valid_before_rst", 32'(io.out_valid), 32'd1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("done_rst_out_valid", 32'(io.out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Randomised traffic with gaps on both handshakes.
    for (int r = 0; r < 300; r++) begin
      logic [1:0]  op;
      logic [31:0] d;
      logic [4:0]  a;
      op = 2'($urandom_range(0, 3));
      d  = $urandom;
      a  = 5'($urandom_range(0, 31));
      run_op(op, d, a, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
